ctrl_gate_bank: RTL and testbench
=================================

# ctrl_gate_bank

Registered, parametrised control-signal selector for the Control Unit decode stage. Each cycle it takes the one-hot opcode-class code from the OPDecoders and the concatenated decoded-signal tables, and selects NSIG control signals in one operation, one signal per channel. Codes that are not one-hot are detected and replaced by a safe default word. Output is a single pipeline stage with a valid/ready handshake so the block can sit between decode and the execute-control register.

## Interface
- NCODE, 10: number of opcode classes, which is also the width of `code`.
- NSIG, 8: number of control-signal channels.
- SAFE_SIG, {NSIG{1'b0}}: word driven on `sig` when `code` is not one-hot.
- CNT_W, 8: width of the illegal-code counter.

- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- code  in  NCODE  one-hot opcode-class select
- dec_data  in  NSIG*NCODE  decoded tables; bit [s*NCODE + c] is signal s for class c
- in_valid  in  1  code/dec_data valid
- in_ready  out  1  stage can accept
- out_valid  out  1  sig/onehot_err valid
- out_ready  in  1  consumer accepts
- sig  out  NSIG  selected control signals (registered)
- onehot_err  out  1  registered; captured word came from a non-one-hot code
- err_clr  in  1  synchronous clear of err_count
- err_count  out  CNT_W  saturating count of accepted illegal codes

## Operation
- Per channel s: sel[s] = |(code & dec_data[s*NCODE +: NCODE]).
- Legality: legal = exactly one bit of `code` set. Zero-hot and multi-hot codes are both illegal.
- Next word: legal ? sel : SAFE_SIG. Next error flag: !legal.
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
- On accept: sig, onehot_err <= next word and flag; out_valid <= 1.
- Else if out_valid & out_ready: out_valid <= 0; sig and onehot_err hold their last values.
- Else: all registers hold. Data is stable while out_valid & !out_ready.
- Simultaneous drain and accept (out_valid & out_ready & in_valid): the new word is loaded and out_valid stays 1. There is no bubble.
- Counter: err_count increments on an accept with illegal code. It saturates at 2^CNT_W-1 and does not wrap.
- err_clr has priority. In a cycle with err_clr=1, err_count <= 0 and a simultaneous illegal accept is not counted.
- Inputs are not sampled while in_ready=0. code and dec_data may change freely when not accepted.

## Timing
- Reset (rst_n=0 at a clk edge): out_valid=0, sig=0, onehot_err=0, err_count=0. in_ready then reads 1.
- Reset mid-transfer: a pending unconsumed word is discarded.
- Latency: 1 cycle. A word accepted at edge N is on sig with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- All outputs except in_ready are registered. in_ready depends only on out_valid and out_ready, with no path from in_valid.

## Configuration
- Macro CTRL_GATE_BANK_ERRCNT_EN.
- Defined: err_count counter and err_clr behave as above.
- Undefined: no counter flops. err_count is tied to 0 and err_clr is ignored. onehot_err and SAFE_SIG substitution remain.

## Test plan
- Reset then idle, NCODE=10, NSIG=8: out_valid=0, sig=0x00, onehot_err=0, err_count=0, in_ready=1.
- Legal select with code=10'b0000000100 (class 2) and dec_data set so that only bit 2 of each channel is 1 for channels 0,3,7: one cycle later sig=0x89, onehot_err=0, out_valid=1.
- Illegal codes with SAFE_SIG=0x5A: code=0, then code=10'b0000100001, both accepted. Each result is sig=0x5A with onehot_err=1. err_count=2 with the macro defined and 0 without it.
- Backpressure: accept word A, hold out_ready=0 for 3 cycles while presenting B. Required: in_ready=0, sig=A stable. Raise out_ready: A drains and B loads on the same edge with out_valid continuously 1.
- Counter saturation, CNT_W=2: apply 5 illegal accepts and check err_count=3. Then apply err_clr=1 together with an illegal accept: err_count=0 on the next cycle.
- Reset mid-operation: out_valid=1 and out_ready=0, then assert rst_n=0 for one edge. Required: out_valid=0, sig=0, err_count=0, and the pending word is lost.

Source files
------------

// File: rtl/ctrl_gate_bank.sv
// ctrl_gate_bank: registered one-hot control-signal selector with valid/ready stage.
// Optional macro CTRL_GATE_BANK_ERRCNT_EN enables the saturating illegal-code
// counter (err_count / err_clr); without it err_count is tied to zero.
module ctrl_gate_bank #(
  parameter int unsigned          NCODE    = 10,
  parameter int unsigned          NSIG     = 8,
  parameter logic [NSIG-1:0]      SAFE_SIG = {NSIG{1'b0}},
  parameter int unsigned          CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCODE-1:0]        code,
  input  logic [NSIG*NCODE-1:0]   dec_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NSIG-1:0]         sig,
  output logic                    onehot_err,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        err_count
);

  logic [NSIG-1:0] sel;
  logic            legal;
  logic            accept;
  logic [NSIG-1:0] next_sig;

  // Per-channel AND-OR select of the decoded table against the class code
  always_comb begin
    sel = '0;
    for (int unsigned s = 0; s < NSIG; s++) begin
      sel[s] = |(code & dec_data[s*NCODE +: NCODE]);
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
  always_comb begin
    legal    = (code != '0) && ((code & (code - NCODE'(1))) == '0);
    next_sig = legal ? sel : SAFE_SIG;
  end

  // Ready depends only on the output register state and the consumer
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output pipeline register; data holds while stalled or after drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      sig        <= '0;
      onehot_err <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      sig        <= next_sig;
      onehot_err <= !legal;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef CTRL_GATE_BANK_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of accepted illegal codes; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (accept && !legal && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  logic unused_err_clr;

  // Counter disabled: no flops, clear input intentionally unused
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_ctrl_gate_bank.sv
// tb_ctrl_gate_bank: randomized and directed checks against a behavioural model.
module tb_ctrl_gate_bank;

  localparam int unsigned NCODE = 10;
  localparam int unsigned NSIG  = 8;
  localparam int unsigned CNT_W = 2;
  localparam logic [7:0]  SAFE  = 8'h5A;
  localparam int          CNT_MAX = 3;
`ifdef CTRL_GATE_BANK_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCODE-1:0]  code = '0;
  logic [NSIG*NCODE-1:0] dec_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [NSIG-1:0]   sig;
  logic              onehot_err;
  logic              err_clr = 1'b0;
  logic [CNT_W-1:0]  err_count;

  int errors = 0;
  int checks = 0;

  // Model state: what the outputs must show
  bit         m_valid = 1'b0;
  logic [7:0] m_sig = '0;
  bit         m_err = 1'b0;
  int         m_cnt = 0;

  ctrl_gate_bank #(
    .NCODE(NCODE), .NSIG(NSIG), .SAFE_SIG(SAFE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .dec_data(dec_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .sig(sig), .onehot_err(onehot_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference word {err, sig}: find the single class index, then read each channel's table bit
  function automatic logic [8:0] ref_word(input logic [NCODE-1:0] c, input logic [NSIG*NCODE-1:0] d);
    int ones;
    int idx;
    logic [7:0] w;
    ones = 0;
    idx = 0;
    for (int i = 0; i < NCODE; i++) if (c[i]) begin ones++; idx = i; end
    if (ones != 1) return {1'b1, SAFE};
    w = '0;
    for (int s = 0; s < NSIG; s++) w[s] = d[s*NCODE + idx];
    return {1'b0, w};
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge
  task automatic tick();
    bit acc;
    bit drain;
    logic [8:0] w;
    acc   = in_valid && (!m_valid || out_ready);
    drain = m_valid && out_ready;
    w     = ref_word(code, dec_data);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 1'b0; m_sig = '0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (acc) begin
        m_valid = 1'b1; m_sig = w[7:0]; m_err = w[8];
      end else if (drain) begin
        m_valid = 1'b0;
      end
      if (ERRCNT) begin
        if (err_clr) m_cnt = 0;
        else if (acc && w[8] && m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (sig !== 8'h00) begin errors++; $display("FAIL reset_sig: got %0h want 00", sig); end
    checks++; if (onehot_err !== 1'b0) begin errors++; $display("FAIL reset_onehot_err: got %0b want 0", onehot_err); end
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_legal();
    code = 10'b0000000100;
    dec_data = '0;
    dec_data[0*NCODE + 2] = 1'b1;
    dec_data[3*NCODE + 2] = 1'b1;
    dec_data[7*NCODE + 2] = 1'b1;
    dec_data[1*NCODE + 3] = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (sig !== 8'h89) begin errors++; $display("FAIL legal_sig: got %0h want 89", sig); end
    checks++; if (onehot_err !== 1'b0) begin errors++; $display("FAIL legal_err: got %0b want 0", onehot_err); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL legal_valid: got %0b want 1", out_valid); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || sig !== 8'h89) begin errors++; $display("FAIL legal_drain: got v=%0b sig=%0h want v=0 sig=89", out_valid, sig); end
  endtask

  task automatic test_illegal();
    logic [NCODE-1:0] codes [2];
    codes[0] = 10'b0000000000;
    codes[1] = 10'b0000100001;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      code = codes[i]; dec_data = 80'({$urandom(), $urandom(), $urandom()}); in_valid = 1'b1;
      tick();
      checks++; if (sig !== SAFE || onehot_err !== 1'b1) begin errors++; $display("FAIL illegal_%0d: got sig=%0h err=%0b want sig=5a err=1", i, sig, onehot_err); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (err_count !== (ERRCNT ? 2'd2 : 2'd0)) begin errors++; $display("FAIL illegal_count: got %0d want %0d", err_count, ERRCNT ? 2 : 0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] a_sig;
    logic [7:0] b_sig;
    logic [8:0] w;
    out_ready = 1'b1; in_valid = 1'b1;
    code = 10'(1) << $urandom_range(0, NCODE-1);
    dec_data = 80'({$urandom(), $urandom(), $urandom()});
    w = ref_word(code, dec_data); a_sig = w[7:0];
    tick();
    out_ready = 1'b0;
    code = 10'(1) << $urandom_range(0, NCODE-1);
    dec_data = ~dec_data;
    w = ref_word(code, dec_data); b_sig = w[7:0];
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %0b want 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || sig !== a_sig) begin errors++; $display("FAIL bp_hold_%0d: got v=%0b sig=%0h want v=1 sig=%0h", i, out_valid, sig, a_sig); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || sig !== b_sig) begin errors++; $display("FAIL bp_swap: got v=%0b sig=%0h want v=1 sig=%0h", out_valid, sig, b_sig); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; err_clr = 1'b1; in_valid = 1'b0;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      code = (i % 2 == 0) ? 10'b0 : 10'b1100000000; in_valid = 1'b1;
      tick();
      checks++; if (err_count !== 2'(m_cnt)) begin errors++; $display("FAIL sat_step_%0d: got %0d want %0d", i, err_count, m_cnt); end
    end
    checks++; if (err_count !== (ERRCNT ? 2'd3 : 2'd0)) begin errors++; $display("FAIL sat_final: got %0d want %0d", err_count, ERRCNT ? 3 : 0); end
    err_clr = 1'b1; code = 10'b0000000011;
    tick();
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", err_count); end
    err_clr = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      code = $urandom_range(0, 1) ? 10'(1) << $urandom_range(0, NCODE-1) : 10'($urandom());
      dec_data = 80'({$urandom(), $urandom(), $urandom()});
      #1;
      checks++; if (in_ready !== (!m_valid || out_ready)) begin errors++; $display("FAIL rnd_in_ready_%0d: got %0b want %0b", i, in_ready, !m_valid || out_ready); end
      tick();
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid_%0d: got %0b want %0b", i, out_valid, m_valid); end
      checks++; if (sig !== m_sig || onehot_err !== m_err) begin errors++; $display("FAIL rnd_word_%0d: got sig=%0h err=%0b want sig=%0h err=%0b", i, sig, onehot_err, m_sig, m_err); end
      checks++; if (err_count !== 2'(m_cnt)) begin errors++; $display("FAIL rnd_count_%0d: got %0d want %0d", i, err_count, m_cnt); end
    end
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; code = 10'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %0b want 1", out_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || sig !== 8'h00 || err_count !== 2'd0) begin errors++; $display("FAIL mid_reset: got v=%0b sig=%0h cnt=%0d want 0/00/0", out_valid, sig, err_count); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_lost: got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
